product_bcd_converter: RTL and testbench

Downstream consumer of the 8x8 signed shift-add multiplier. It takes the 16-bit two's-complement product {Aval, Bval} and converts it, sequentially by double-dabble, to a sign flag plus five BCD digits for decimal display on the HEX outputs. It runs one conversion per Start pulse, holds the result until the next conversion completes, and signals completion with a one-cycle Done pulse.

---
 rtl/product_bcd_pkg.sv | 11 +
 rtl/product_bcd_converter_if.sv | 12 +
 rtl/bcd_digit_adjust.sv | 10 +
 rtl/product_bcd_converter.sv | 86 ++++++++
 tb/tb_product_bcd_converter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/product_bcd_pkg.sv
// product_bcd_pkg: shared states, BCD adjust constants and counter-width helper
package product_bcd_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD = 4'd3;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/product_bcd_converter_if.sv
// product_bcd_converter_if: request/result bundle between the product source and the BCD converter
// Start/Product flow master->slave; Busy/Done/Neg/Digits flow slave->master.
interface product_bcd_converter_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
    logic                  Start;
    logic [WIDTH-1:0]      Product;
    logic                  Busy;
    logic                  Done;
    logic                  Neg;
    logic [4*DIGITS-1:0]   Digits;
    modport master(output Start, Product, input Busy, Done, Neg, Digits);
    modport slave(input Start, Product, output Busy, Done, Neg, Digits);
endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble nibble correction, adds 3 when the digit is 5 or more
// digit_i: BCD nibble before shift; digit_o: corrected nibble.
module bcd_digit_adjust
    import product_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    assign digit_o = digit_i >= BCD_ADJ_THRESH ? digit_i + BCD_ADJ_ADD : digit_i;
endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble of a signed product into sign + BCD digits
// Clk/Reset: clock and async active-high reset; bus: Start/Product in, Busy/Done/Neg/Digits out.
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGITS = 5
) (
    input  logic                    Clk,
    input  logic                    Reset,
    product_bcd_converter_if.slave  bus
);
    localparam int CW = clog2(WIDTH);
    localparam int BW = 4 * DIGITS;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_q, prod_d, mag_q, mag_d, mag_sh;
    logic [BW-1:0]   bcd_q, bcd_d, bcd_adj, bcd_sh, digits_q, digits_d;
    logic            neg_q, neg_d, neg_out_q, neg_out_d;
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (.digit_i(bcd_q[4*i +: 4]), .digit_o(bcd_adj[4*i +: 4]));
    end
    // Adjusted BCD and magnitude shift left as one register; mag MSB feeds the BCD LSB.
    assign bcd_sh = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    assign mag_sh = {mag_q[WIDTH-2:0], 1'b0};
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        prod_d = prod_q;
        mag_d = mag_q;
        bcd_d = bcd_q;
        neg_d = neg_q;
        digits_d = digits_q;
        neg_out_d = neg_out_q;
        case (state_q)
            IDLE: if (bus.Start) begin
                state_d = LOAD;
                prod_d = bus.Product;
            end
            LOAD: begin
                neg_d = prod_q[WIDTH-1];
                // Unsigned negate keeps the most negative input exact (8000 -> 32768).
                mag_d = prod_q[WIDTH-1] ? -prod_q : prod_q;
                bcd_d = '0;
                cnt_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = bcd_sh;
                mag_d = mag_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    digits_d = bcd_sh;
                    neg_out_d = neg_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            prod_q <= '0;
            mag_q <= '0;
            bcd_q <= '0;
            neg_q <= 1'b0;
            digits_q <= '0;
            neg_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            prod_q <= prod_d;
            mag_q <= mag_d;
            bcd_q <= bcd_d;
            neg_q <= neg_d;
            digits_q <= digits_d;
            neg_out_q <= neg_out_d;
        end
    end
    assign bus.Busy = state_q != IDLE;
    assign bus.Done = state_q == DONE;
    assign bus.Neg = neg_out_q;
    assign bus.Digits = digits_q;
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: directed vectors checked against a cycle-level decimal model
module tb_product_bcd_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();
    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (.Clk(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [20:0] model(input logic [15:0] p);
        int v = $signed(p);
        int m = v < 0 ? -v : v;
        logic [19:0] d = '0;
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {v < 0, d};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: a conversion occupies 18 busy cycles; the result appears with Done on the last.
    int busy_left;
    logic [15:0] cap;
    logic exp_neg;
    logic [19:0] exp_dig;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left <= 0;
            cap <= '0;
            exp_neg <= 1'b0;
            exp_dig <= '0;
        end else if (busy_left == 0) begin
            if (bus.Start) begin
                cap <= bus.Product;
                busy_left <= 18;
            end
        end else begin
            busy_left <= busy_left - 1;
            if (busy_left == 2) {exp_neg, exp_dig} <= model(cap);
        end
    end
    always @(negedge clk) begin
        chk("busy", 32'(bus.Busy), 32'(busy_left != 0));
        chk("done", 32'(bus.Done), 32'(busy_left == 1));
        chk("neg", 32'(bus.Neg), 32'(exp_neg));
        chk("digits", 32'(bus.Digits), 32'(exp_dig));
    end
    task automatic convert(input logic [15:0] p, input logic en, input logic [19:0] ed, input string nm);
        int n;
        int busy_n;
        @(negedge clk);
        bus.Product = p;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        n = 1;
        busy_n = int'(bus.Busy);
        while (!bus.Done && n < 40) begin
            @(negedge clk);
            n++;
            busy_n += int'(bus.Busy);
        end
        chk({nm, "_latency"}, 32'(n), 32'd18);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd18);
        chk({nm, "_neg"}, 32'(bus.Neg), 32'(en));
        chk({nm, "_digits"}, 32'(bus.Digits), 32'(ed));
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(bus.Busy), 32'd0);
    endtask
    initial begin
        int dn;
        bus.Start = 1'b0;
        bus.Product = '0;
        repeat (2) @(negedge clk);
        chk("reset_digits", 32'(bus.Digits), 32'd0);
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        rst = 1'b0;
        convert(16'hFFEB, 1'b1, 20'h00021, "m21");
        convert(16'h4000, 1'b0, 20'h16384, "p16384");
        convert(16'h8000, 1'b1, 20'h32768, "m32768");
        convert(16'h0000, 1'b0, 20'h00000, "zero");
        convert(16'h007F, 1'b0, 20'h00127, "p127");
        @(negedge clk);
        bus.Product = 16'h0315;
        bus.Start = 1'b1;
        dn = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.Start = (k == 5 || k == 12);
            if (k == 5 || k == 12) bus.Product = 16'hFFFF;
            dn += int'(bus.Done);
        end
        bus.Start = 1'b0;
        chk("ignore_start_dones", 32'(dn), 32'd1);
        chk("ignore_start_digits", 32'(bus.Digits), 32'h00789);
        chk("ignore_start_neg", 32'(bus.Neg), 32'd0);
        convert(16'h1234, 1'b0, 20'h04660, "p4660");
        @(negedge clk);
        bus.Product = 16'hFF9C;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.Busy), 32'd0);
        chk("async_rst_done", 32'(bus.Done), 32'd0);
        chk("async_rst_neg", 32'(bus.Neg), 32'd0);
        chk("async_rst_digits", 32'(bus.Digits), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        convert(16'hFF85, 1'b1, 20'h00123, "m123");
        @(negedge clk);
        bus.Product = 16'h0001;
        bus.Start = 1'b1;
        dn = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            dn += int'(bus.Done);
        end
        bus.Start = 1'b0;
        chk("b2b_dones", 32'(dn), 32'd2);
        chk("b2b_digits", 32'(bus.Digits), 32'h00001);
        repeat (25) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
